// File: rtl/sram_bar_writer.sv
// sram_bar_writer: stores a selectable subset of music bars into external SRAM
// at fixed bar slots, and zero-fills a region of SRAM on request.
//
// Ports
//   i_bclk        clock, all state changes on the rising edge
//   i_rst         synchronous active-low reset
//   i_mode        1 = write mode enabled, 0 = idle / abort an active save
//   i_save        active-low save request, edge-armed
//   i_clear       active-low clear request, overrides every other transition
//   i_bar_mask    bar-select bits, snapshotted when a save is accepted
//   i_music_data  bar payload, word k at [k*DATA_W +: DATA_W], snapshotted per bar
//   o_SRAM_DQ     write data, valid while o_dq_oe = 1
//   o_dq_oe       data-bus drive enable, always !o_write_n
//   o_write_n     SRAM write strobe, active-low
//   o_addr        SRAM address
//   o_busy        high in CLEAR, SCAN, WRITE and DONE
//   o_done        one-cycle pulse when a save completes
//   o_flag        stretched activity indicator
module sram_bar_writer #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned NUM_BARS      = 8,
  parameter int unsigned WORDS_PER_BAR = 4,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned CLEAR_WORDS   = 256,
  parameter int unsigned FLAG_CYCLES   = 200000
) (
  input  logic                            i_bclk,
  input  logic                            i_rst,
  input  logic                            i_mode,
  input  logic                            i_save,
  input  logic                            i_clear,
  input  logic [NUM_BARS-1:0]             i_bar_mask,
  input  logic [WORDS_PER_BAR*DATA_W-1:0] i_music_data,
  output logic [DATA_W-1:0]               o_SRAM_DQ,
  output logic                            o_dq_oe,
  output logic                            o_write_n,
  output logic [ADDR_W-1:0]               o_addr,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_flag
);

  localparam int unsigned BarW  = $clog2(NUM_BARS) + 1;
  localparam int unsigned WordW = $clog2(WORDS_PER_BAR) + 1;
  localparam int unsigned ClrW  = $clog2(CLEAR_WORDS) + 1;
  localparam int unsigned FlagW = $clog2(FLAG_CYCLES + 1);

  localparam logic [BarW-1:0]   LastBar  = BarW'(NUM_BARS - 1);
  localparam logic [WordW-1:0]  LastWord = WordW'(WORDS_PER_BAR - 1);
  localparam logic [ClrW-1:0]   ClrEnd   = ClrW'(CLEAR_WORDS);
  localparam logic [FlagW-1:0]  FlagLoad = FlagW'(FLAG_CYCLES);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StReady,
    StScan,
    StWrite,
    StDone
  } state_e;

  state_e                            state_q;
  logic [BarW-1:0]                   bar_q;
  logic [WordW-1:0]                  word_q;
  logic [ClrW-1:0]                   clr_idx_q;
  logic [FlagW-1:0]                  flag_cnt_q;
  logic [NUM_BARS-1:0]               mask_q;
  logic [WORDS_PER_BAR*DATA_W-1:0]   data_q;
  logic                              armed_q;

  logic                              mask_hit;
  logic [ADDR_W-1:0]                 bar_addr;
  logic [DATA_W-1:0]                 next_word;

  assign mask_hit  = |(mask_q & (NUM_BARS'(1) << bar_q));
  // Slot 0 is reserved, so bar b lives at slot b+1.
  assign bar_addr  = BaseAddr + ADDR_W'((32'(bar_q) + 32'd1) * WORDS_PER_BAR);
  assign next_word = DATA_W'(data_q >> ((32'(word_q) + 32'd1) * DATA_W));

  always_ff @(posedge i_bclk) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      bar_q      <= '0;
      word_q     <= '0;
      clr_idx_q  <= '0;
      flag_cnt_q <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      armed_q    <= 1'b1;
      o_write_n  <= 1'b1;
      o_dq_oe    <= 1'b0;
      o_addr     <= BaseAddr;
      o_SRAM_DQ  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_flag     <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_write_n <= 1'b1;
      o_dq_oe   <= 1'b0;

      // A save held low never retriggers; release re-arms it.
      if (i_save) armed_q <= 1'b1;

      if (flag_cnt_q != '0) begin
        flag_cnt_q <= flag_cnt_q - 1'b1;
        o_flag     <= (flag_cnt_q != FlagW'(1));
      end

      if (!i_clear) begin
        // Holding clear keeps restarting it, and keeps retriggering the flag.
        state_q    <= StClear;
        clr_idx_q  <= '0;
        o_busy     <= 1'b1;
        flag_cnt_q <= FlagLoad;
        o_flag     <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            o_busy <= 1'b0;
            if (i_mode) state_q <= StReady;
          end
          StReady: begin
            o_busy <= 1'b0;
            if (!i_mode) begin
              state_q <= StIdle;
            end else if (!i_save && armed_q) begin
              mask_q     <= i_bar_mask;
              bar_q      <= '0;
              armed_q    <= 1'b0;
              flag_cnt_q <= FlagLoad;
              o_flag     <= 1'b1;
              o_busy     <= 1'b1;
              state_q    <= StScan;
            end
          end
          StScan: begin
            if (!i_mode) begin
              o_busy  <= 1'b0;
              state_q <= StIdle;
            end else if (mask_hit) begin
              data_q    <= i_music_data;
              word_q    <= '0;
              o_write_n <= 1'b0;
              o_dq_oe   <= 1'b1;
              o_addr    <= bar_addr;
              o_SRAM_DQ <= i_music_data[DATA_W-1:0];
              state_q   <= StWrite;
            end else if (bar_q != LastBar) begin
              bar_q <= bar_q + 1'b1;
            end else begin
              o_done  <= 1'b1;
              state_q <= StDone;
            end
          end
          StWrite: begin
            if (!i_mode) begin
              o_busy  <= 1'b0;
              state_q <= StIdle;
            end else if (word_q != LastWord) begin
              word_q    <= word_q + 1'b1;
              o_write_n <= 1'b0;
              o_dq_oe   <= 1'b1;
              o_addr    <= o_addr + 1'b1;
              o_SRAM_DQ <= next_word;
            end else if (bar_q != LastBar) begin
              bar_q   <= bar_q + 1'b1;
              state_q <= StScan;
            end else begin
              o_done  <= 1'b1;
              state_q <= StDone;
            end
          end
          StDone: begin
            o_busy  <= 1'b0;
            state_q <= i_mode ? StReady : StIdle;
          end
          StClear: begin
            if (clr_idx_q == ClrEnd) begin
              o_busy  <= 1'b0;
              state_q <= i_mode ? StReady : StIdle;
            end else begin
              o_write_n <= 1'b0;
              o_dq_oe   <= 1'b1;
              o_SRAM_DQ <= '0;
              o_addr    <= BaseAddr + ADDR_W'(clr_idx_q);
              clr_idx_q <= clr_idx_q + 1'b1;
            end
          end
          default: begin
            o_busy  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_bar_writer.sv
// Self-checking bench for sram_bar_writer. A timing-level model fills per-cycle
// expectation arrays from the save/clear schedule rules; one compare process
// checks every output each cycle, and scenario code pins the model with literals.
module tb_sram_bar_writer;

  localparam int DW   = 16;
  localparam int AW   = 20;
  localparam int NB   = 8;
  localparam int WPB  = 4;
  localparam int BASE = 0;
  localparam int CW   = 256;
  localparam int FC   = 40;
  localparam int MAXC = 4096;

  logic              bclk = 1'b0;
  logic              rst;
  logic              mode;
  logic              save;
  logic              clear;
  logic [NB-1:0]     bar_mask;
  logic [WPB*DW-1:0] music_data;
  logic [DW-1:0]     sram_dq;
  logic              dq_oe;
  logic              write_n;
  logic [AW-1:0]     addr;
  logic              busy;
  logic              done;
  logic              flag;

  sram_bar_writer #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .NUM_BARS     (NB),
    .WORDS_PER_BAR(WPB),
    .BASE_ADDR    (BASE),
    .CLEAR_WORDS  (CW),
    .FLAG_CYCLES  (FC)
  ) dut (
    .i_bclk      (bclk),
    .i_rst       (rst),
    .i_mode      (mode),
    .i_save      (save),
    .i_clear     (clear),
    .i_bar_mask  (bar_mask),
    .i_music_data(music_data),
    .o_SRAM_DQ   (sram_dq),
    .o_dq_oe     (dq_oe),
    .o_write_n   (write_n),
    .o_addr      (addr),
    .o_busy      (busy),
    .o_done      (done),
    .o_flag      (flag)
  );

  always #5 bclk = ~bclk;

  int cyc = 0;
  always @(posedge bclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Expected outputs indexed by cycle (value visible after posedge number c).
  bit          exp_wn   [MAXC];
  int          exp_addr [MAXC];
  int          exp_dq   [MAXC];
  bit          exp_done [MAXC];
  bit          exp_busy [MAXC];
  bit          trig     [MAXC];
  logic [63:0] bar_data [NB];

  task automatic plan_quiet(input int from);
    for (int c = from; c < MAXC; c++) begin
      exp_wn[c]   = 1'b1;
      exp_done[c] = 1'b0;
      exp_busy[c] = 1'b0;
    end
  endtask

  // Save accepted at edge a: one scan cycle per bar, WPB writes per selected bar,
  // then a single done cycle.
  task automatic plan_save(input int a, input logic [NB-1:0] m, output int done_c);
    int c;
    c = a;
    trig[a] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      exp_busy[c] = 1'b1;
      c++;
      if (m[b]) begin
        for (int k = 0; k < WPB; k++) begin
          exp_wn[c]   = 1'b0;
          exp_addr[c] = (BASE + (b + 1) * WPB + k) % (1 << AW);
          exp_dq[c]   = int'(bar_data[b][k*DW +: DW]);
          exp_busy[c] = 1'b1;
          c++;
        end
      end
    end
    exp_done[c] = 1'b1;
    exp_busy[c] = 1'b1;
    done_c = c;
  endtask

  // Clear low at edges e..e+h-1, then CW zero writes, then back to quiet.
  task automatic plan_clear(input int e, input int h);
    plan_quiet(e);
    for (int i = 0; i < h; i++) begin
      exp_busy[e+i] = 1'b1;
      trig[e+i]     = 1'b1;
    end
    for (int i = 0; i < CW; i++) begin
      exp_wn[e+h+i]   = 1'b0;
      exp_addr[e+h+i] = (BASE + i) % (1 << AW);
      exp_dq[e+h+i]   = 0;
      exp_busy[e+h+i] = 1'b1;
    end
    plan_quiet(e + h + CW);
  endtask

  int chk_from = MAXC;
  int last_trig = -1;
  int flag_fall = -1;
  bit prev_flag = 1'b0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int done_q[$];

  always @(negedge bclk) begin : cmp
    int c;
    bit ef;
    if (cyc >= chk_from && cyc < MAXC) begin
      c = cyc;
      if (trig[c]) last_trig = c;
      ef = (last_trig >= 0) && (c - last_trig < FC);
      if (write_n === 1'b0) begin
        wr_addr_q.push_back(int'(addr));
        wr_data_q.push_back(int'(sram_dq));
      end
      if (done === 1'b1) done_q.push_back(cyc + 1);
      if (prev_flag && flag === 1'b0) flag_fall = c;
      prev_flag = (flag === 1'b1);
      check("write_n", 64'(write_n), 64'(exp_wn[c]));
      check("dq_oe", 64'(dq_oe), 64'(!exp_wn[c]));
      check("done", 64'(done), 64'(exp_done[c]));
      check("busy", 64'(busy), 64'(exp_busy[c]));
      check("flag", 64'(flag), 64'(ef));
      if (!exp_wn[c]) begin
        check("addr", 64'(addr), 64'(exp_addr[c]));
        check("data", 64'(sram_dq), 64'(exp_dq[c]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge bclk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_q.delete();
    flag_fall = -1;
  endtask

  initial begin
    int a, a2, e, dc, nz, ea, ed;
    logic [WPB*DW-1:0] d1, d2;
    d1 = {16'hA004, 16'hA003, 16'hA002, 16'hA001};
    d2 = {16'hB004, 16'hB003, 16'hB002, 16'hB001};
    rst = 1'b0; mode = 1'b0; save = 1'b1; clear = 1'b1;
    bar_mask = '0; music_data = '0;
    plan_quiet(0);
    repeat (3) @(posedge bclk);
    step(1);
    check("reset write_n", 64'(write_n), 64'd1);
    check("reset dq_oe", 64'(dq_oe), 64'd0);
    check("reset addr", 64'(addr), 64'(BASE));
    check("reset dq", 64'(sram_dq), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset flag", 64'(flag), 64'd0);
    rst = 1'b1;
    chk_from = cyc + 1;
    step(2);

    // Clear held low 3 cycles, mode off: 256 zero writes at 0..255, then IDLE.
    clear_logs();
    clear = 1'b0; e = cyc + 1; plan_clear(e, 3);
    step(3); clear = 1'b1;
    step(CW + 5);
    check("clear write count", 64'(wr_addr_q.size()), 64'd256);
    if (wr_addr_q.size() == 256) begin
      check("clear first addr", 64'(wr_addr_q[0]), 64'd0);
      check("clear last addr", 64'(wr_addr_q[255]), 64'd255);
    end
    nz = 0;
    foreach (wr_data_q[i]) if (wr_data_q[i] != 0) nz++;
    check("clear data zero", 64'(nz), 64'd0);
    check("clear no done", 64'(done_q.size()), 64'd0);
    check("clear flag fall", 64'(flag_fall), 64'(e + 2 + FC));
    check("clear idle busy", 64'(busy), 64'd0);

    // Full mask save.
    mode = 1'b1; step(1);
    clear_logs();
    music_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bar_mask = 8'hFF;
    for (int b = 0; b < NB; b++) bar_data[b] = music_data;
    save = 1'b0; a = cyc + 1; plan_save(a, 8'hFF, dc);
    check("model full done edge", 64'(dc + 1), 64'(a + 41));
    step(1); save = 1'b1;
    step(45);
    check("full done count", 64'(done_q.size()), 64'd1);
    if (done_q.size() == 1) check("full done edge", 64'(done_q[0]), 64'(a + 41));
    check("full write count", 64'(wr_addr_q.size()), 64'd32);
    if (wr_addr_q.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        check("full addr", 64'(wr_addr_q[i]), 64'(4 + i));
        check("full data", 64'(wr_data_q[i]), 64'(16'h1111 * (i % 4 + 1)));
      end
    end

    // Mask 1000_0001 with mask and data changed after the save starts.
    clear_logs();
    music_data = d1; bar_mask = 8'h81;
    bar_data[0] = d1;
    for (int b = 1; b < NB; b++) bar_data[b] = d2;
    save = 1'b0; a = cyc + 1; plan_save(a, 8'h81, dc);
    step(1); save = 1'b1;
    step(1); bar_mask = 8'h02; music_data = d2;
    step(20);
    check("m81 done count", 64'(done_q.size()), 64'd1);
    if (done_q.size() == 1) check("m81 done edge", 64'(done_q[0]), 64'(a + 17));
    check("m81 write count", 64'(wr_addr_q.size()), 64'd8);
    if (wr_addr_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        ea = (i < 4) ? 4 + i : 28 + i;
        ed = (i < 4) ? 'hA001 + i : 'hB001 + i - 4;
        check("m81 addr", 64'(wr_addr_q[i]), 64'(ea));
        check("m81 data", 64'(wr_data_q[i]), 64'(ed));
      end
    end

    // Save held low 100 cycles: one save only; release then press: second save.
    clear_logs();
    music_data = d1; bar_mask = 8'h01;
    for (int b = 0; b < NB; b++) bar_data[b] = d1;
    save = 1'b0; a = cyc + 1; plan_save(a, 8'h01, dc);
    step(100);
    check("held single done", 64'(done_q.size()), 64'd1);
    if (done_q.size() == 1) check("held done edge", 64'(done_q[0]), 64'(a + 13));
    save = 1'b1; step(1);
    save = 1'b0; a2 = cyc + 1; plan_save(a2, 8'h01, dc);
    step(1); save = 1'b1;
    step(20);
    check("rearm done count", 64'(done_q.size()), 64'd2);
    if (done_q.size() == 2) check("rearm done edge", 64'(done_q[1]), 64'(a2 + 13));

    // Abort after the 2nd word of bar 0.
    clear_logs();
    save = 1'b0; a = cyc + 1; plan_save(a, 8'h01, dc);
    step(1); save = 1'b1;
    step(2); mode = 1'b0; plan_quiet(a + 3);
    step(6);
    check("abort write count", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) check("abort last addr", 64'(wr_addr_q[1]), 64'd5);
    check("abort no done", 64'(done_q.size()), 64'd0);
    mode = 1'b1; step(1);

    // Clear mid-write: overrides the save, then returns to READY.
    clear_logs();
    bar_mask = 8'hFF;
    save = 1'b0; a = cyc + 1; plan_save(a, 8'hFF, dc);
    step(1); save = 1'b1;
    step(3);
    clear = 1'b0; e = cyc + 1; plan_clear(e, 2);
    step(2); clear = 1'b1;
    step(CW + 20);
    check("midclr no done", 64'(done_q.size()), 64'd0);
    check("midclr write count", 64'(wr_addr_q.size()), 64'd259);
    if (wr_addr_q.size() == 259) begin
      check("midclr first zero addr", 64'(wr_addr_q[3]), 64'd0);
      check("midclr last addr", 64'(wr_addr_q[258]), 64'd255);
    end
    check("midclr flag fall", 64'(flag_fall), 64'(e + 1 + FC));
    check("midclr ready busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_bar_writer.md
# sram_bar_writer

Parametrised successor to the single-configuration bar writer in the SDRAM_Camera music path. It stores a selectable subset of NUM_BARS music bars, each WORDS_PER_BAR × DATA_W bits, into external SRAM at fixed bar slots. It also zero-fills a configurable SRAM region on request. New behaviour over the previous generation:
- save is edge-armed
- bar data and bar mask are snapshotted
- explicit done, busy and output-enable outputs
- mid-write abort and clear are defined

## Interface
Parameters:
- DATA_W, 16, SRAM word width
- ADDR_W, 20, SRAM address width
- NUM_BARS, 8, number of bar slots
- WORDS_PER_BAR, 4, words per bar (≥1)
- BASE_ADDR, 0, region base address
- CLEAR_WORDS, 256, words zeroed by a clear
- FLAG_CYCLES, 200000, length of the o_flag stretch

Ports:
- i_bclk  in  1  clock; all state changes on its rising edge
- i_rst  in  1  reset; synchronous and active-low
- i_mode  in  1  1 = write mode enabled; 0 = idle or abort
- i_save  in  1  active-low save request
- i_clear  in  1  active-low clear request; highest priority after reset
- i_bar_mask  in  NUM_BARS  bar-select bits; bit b set = store bar b
- i_music_data  in  NUM_BARS×0+WORDS_PER_BAR×DATA_W  bar payload; word k = [k×DATA_W +: DATA_W]
- o_SRAM_DQ  out  DATA_W  write data; valid when o_dq_oe = 1
- o_dq_oe  out  1  data-bus drive enable; equals !o_write_n
- o_write_n  out  1  SRAM write strobe, active-low
- o_addr  out  ADDR_W  SRAM address
- o_busy  out  1  high in CLEAR, SCAN, WRITE and DONE
- o_done  out  1  one-cycle pulse when a save completes
- o_flag  out  1  activity indicator, stretched

## Operation
- States: IDLE, CLEAR, READY, SCAN, WRITE, DONE. All outputs are registered.
- Reset (i_rst = 0 at an edge) sets:
  - state = IDLE, o_write_n = 1, o_dq_oe = 0
  - o_addr = BASE_ADDR, o_SRAM_DQ = 0
  - o_busy = 0, o_done = 0, o_flag = 0
  - armed = 1, flag counter = 0
- IDLE:
  - strobe inactive
  - i_mode = 1 → READY
- READY:
  - i_mode = 0 → IDLE.
  - i_save = 0 with armed = 1 → accept the save:
    - snapshot i_bar_mask
    - bar index b = 0, armed = 0
    - start o_flag → SCAN
  - armed returns to 1 on any cycle with i_save = 1. A save held low never retriggers.
- SCAN (one cycle per bar):
  - mask[b] = 1 → snapshot i_music_data, set word index k = 0 → WRITE.
  - mask[b] = 0 and b < NUM_BARS−1 → b+1, stay in SCAN.
  - mask[b] = 0 and b = NUM_BARS−1 → DONE.
- WRITE (WORDS_PER_BAR cycles):
  - each cycle drives o_write_n = 0, o_dq_oe = 1
  - o_addr = BASE_ADDR + (b+1)×WORDS_PER_BAR + k; slot 0 is reserved
  - o_SRAM_DQ = snapshot word k
  - after k = WORDS_PER_BAR−1:
    - b < NUM_BARS−1 → b+1, SCAN
    - otherwise → DONE
- DONE:
  - o_done = 1 for exactly one cycle
  - i_mode = 1 → READY; otherwise → IDLE
- i_mode = 0 during SCAN or WRITE:
  - next cycle: IDLE, o_write_n = 1, o_dq_oe = 0
  - no o_done pulse
  - a partially written bar is left as is
- CLEAR:
  - Entered from any state when i_clear = 0; this overrides every other transition.
  - While i_clear is held low: clear index = 0, no writes, o_busy = 1.
  - After release, one word per cycle:
    - o_write_n = 0, o_dq_oe = 1, o_SRAM_DQ = 0
    - o_addr = BASE_ADDR + i, for i = 0..CLEAR_WORDS−1
  - After the last word → READY if i_mode = 1, else IDLE. No o_done pulse.
  - i_clear asserted again mid-clear restarts at i = 0.
- o_flag:
  - A save accept or CLEAR entry loads counter = FLAG_CYCLES and sets o_flag = 1.
  - The counter decrements every cycle; o_flag clears when it reaches 0.
  - A retrigger reloads the counter.
- Arithmetic:
  - address sums are computed in ADDR_W bits and wrap modulo 2^ADDR_W
  - bar/word counters are sized $clog2(N)+1; no wrap inside a save

## Timing
- Save accepted at edge T:
  - SCAN of bar 0 at T+1
  - first write cycle at T+2 if mask[0] = 1
- Total cycles from accept to the o_done pulse:
  - 1 + NUM_BARS + popcount(mask)×WORDS_PER_BAR
  - o_done appears in the cycle after the last SCAN or WRITE cycle
- Empty mask: o_done at T+NUM_BARS+1, no writes.
- Clear: the first zero write is 1 cycle after i_clear returns high; lasts CLEAR_WORDS cycles.
- Writes are back-to-back inside a bar; each bar boundary costs one SCAN cycle with o_write_n = 1.
- Simultaneous events, in priority order: i_rst > i_clear > i_mode abort > save/scan.

## Test plan
- Reset → every output at its reset value.
- Default parameters, i_clear low 3 cycles then high → exactly 256 strobes at addresses 0..255, data 0, then IDLE, o_busy low.
- i_mode = 1, mask = 8'hFF, data words 16'h1111/2222/3333/4444, i_save low → 32 writes at 4..35 in word order, o_done at T+41.
- Mask = 8'b1000_0001:
  - writes at 4..7 and 32..35
  - i_bar_mask changed mid-save → ignored
  - o_done at T+17
- i_save held low 100 cycles → one save only; release high, then low → second save accepted.
- i_mode drops after the 2nd word of bar 0 → strobe high next cycle, IDLE, no o_done. i_clear low mid-write → CLEAR entered next cycle; o_flag high for FLAG_CYCLES after the last trigger.
